// File: rtl/ff_stream_capture.sv
// Serial capture: samples Q on CE-qualified edges, assembles WIDTH-bit words and
// presents them on a one-entry VALID/READY register with sticky overflow and a word count.
module ff_stream_capture #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 CK,
    input  logic                 RST,
    input  logic                 CE,
    input  logic                 Q,
    input  logic                 SYNC,
    output logic [WIDTH-1:0]     DATA,
    output logic                 VALID,
    input  logic                 READY,
    output logic                 OVERFLOW,
    output logic [CNT_WIDTH-1:0] WORD_CNT
);

    localparam int unsigned BitCntW = $clog2(WIDTH);
    localparam logic [BitCntW-1:0] LastBit = BitCntW'(WIDTH - 1);

    logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]     shift_q, shift_d;
    logic [WIDTH-1:0]     shift_base, shift_in;
    logic [WIDTH-1:0]     data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 overflow_q, overflow_d;
    logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
    logic                 complete;

    always_comb begin
        // SYNC starts a fresh word, so the new bit shifts into an empty register.
        shift_base = SYNC ? '0 : shift_q;
        if (MSB_FIRST) begin
            shift_in = {shift_base[WIDTH-2:0], Q};
        end else begin
            shift_in = {Q, shift_base[WIDTH-1:1]};
        end
        complete = CE && !SYNC && (bit_cnt_q == LastBit);

        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        valid_d    = valid_q;
        overflow_d = overflow_q;
        word_cnt_d = word_cnt_q;

        if (CE) begin
            if (SYNC) begin
                bit_cnt_d = BitCntW'(1);
                shift_d   = shift_in;
            end else if (complete) begin
                bit_cnt_d = '0;
                shift_d   = '0;
            end else begin
                bit_cnt_d = bit_cnt_q + BitCntW'(1);
                shift_d   = shift_in;
            end
        end

        if (complete) begin
            word_cnt_d = word_cnt_q + CNT_WIDTH'(1);
            if (!valid_q || READY) begin
                data_d  = shift_in;
                valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (valid_q && READY) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            word_cnt_q <= '0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    assign DATA     = data_q;
    assign VALID    = valid_q;
    assign OVERFLOW = overflow_q;
    assign WORD_CNT = word_cnt_q;

endmodule

// File: tb/tb_ff_stream_capture.sv
// Bench for ff_stream_capture: MSB-first and LSB-first instances share stimulus and are
// compared every cycle against a bit-list model, plus a table of directed words.
module tb_ff_stream_capture;

    logic ck = 1'b0;
    logic rst, ce, q, sync, ready;
    logic [7:0]  data_m, data_l;
    logic        valid_m, valid_l, ovf_m, ovf_l;
    logic [15:0] cnt_m;
    logic [3:0]  cnt_l;

    int checks = 0;
    int errors = 0;

    always #5 ck = ~ck;

    ff_stream_capture #(.WIDTH(8), .MSB_FIRST(1'b1), .CNT_WIDTH(16)) dut_m (
        .CK(ck), .RST(rst), .CE(ce), .Q(q), .SYNC(sync), .DATA(data_m), .VALID(valid_m),
        .READY(ready), .OVERFLOW(ovf_m), .WORD_CNT(cnt_m)
    );

    // Narrow counter on the LSB-first instance so random traffic exercises wrap-around.
    ff_stream_capture #(.WIDTH(8), .MSB_FIRST(1'b0), .CNT_WIDTH(4)) dut_l (
        .CK(ck), .RST(rst), .CE(ce), .Q(q), .SYNC(sync), .DATA(data_l), .VALID(valid_l),
        .READY(ready), .OVERFLOW(ovf_l), .WORD_CNT(cnt_l)
    );

    // Reference model: list of received bits of the word in progress.
    bit          bits[$];
    logic [7:0]  m_msb, m_lsb;
    bit          m_valid, m_ovf;
    int unsigned m_cnt;

    task automatic model_step();
        bit done;
        logic [7:0] w_msb, w_lsb;
        if (rst) begin
            bits.delete();
            m_msb = '0; m_lsb = '0; m_valid = 0; m_ovf = 0; m_cnt = 0;
            return;
        end
        done = 0;
        if (ce) begin
            if (sync) bits.delete();
            bits.push_back(q);
            if (bits.size() == 8) begin
                done = 1;
                m_cnt++;
                for (int i = 0; i < 8; i++) begin
                    w_msb[7-i] = bits[i];
                    w_lsb[i]   = bits[i];
                end
                if (!m_valid || ready) begin
                    m_msb = w_msb; m_lsb = w_lsb; m_valid = 1;
                end else begin
                    m_ovf = 1;
                end
                bits.delete();
            end
        end
        if (!done && m_valid && ready) m_valid = 0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        check("model data_msb", 32'(data_m), 32'(m_msb));
        check("model data_lsb", 32'(data_l), 32'(m_lsb));
        check("model valid_m", 32'(valid_m), 32'(m_valid));
        check("model valid_l", 32'(valid_l), 32'(m_valid));
        check("model ovf_m", 32'(ovf_m), 32'(m_ovf));
        check("model ovf_l", 32'(ovf_l), 32'(m_ovf));
        check("model cnt_m", 32'(cnt_m), m_cnt & 32'hFFFF);
        check("model cnt_l", 32'(cnt_l), m_cnt & 32'hF);
    endtask

    task automatic tick(input bit r, input bit c, input bit d, input bit s, input bit rd);
        rst = r; ce = c; q = d; sync = s; ready = rd;
        model_step();
        @(posedge ck);
        #1;
        check_model();
    endtask

    // Sends 8 bits, first bit = w[7]; READY only on the final edge if ready_end.
    task automatic send_word(input logic [7:0] w, input bit ready_end, input bit alt,
                             input bit use_sync);
        for (int i = 0; i < 8; i++) begin
            if (alt) tick(0, 0, bit'($urandom & 1), bit'($urandom & 1), 0);
            tick(0, 1, w[7-i], use_sync && (i == 0), (i == 7) ? ready_end : 1'b0);
        end
    endtask

    task automatic check_outs(input string name, input logic [7:0] e_msb,
                              input logic [7:0] e_lsb, input bit e_valid, input bit e_ovf,
                              input int unsigned e_cnt);
        check({name, " data_msb"}, 32'(data_m), 32'(e_msb));
        check({name, " data_lsb"}, 32'(data_l), 32'(e_lsb));
        check({name, " valid"}, 32'(valid_m), 32'(e_valid));
        check({name, " overflow"}, 32'(ovf_m), 32'(e_ovf));
        check({name, " cnt_m"}, 32'(cnt_m), e_cnt & 32'hFFFF);
        check({name, " cnt_l"}, 32'(cnt_l), e_cnt & 32'hF);
    endtask

    typedef struct {
        string       name;
        logic [7:0]  word;
        bit          ready_end;
        bit          alt;
        logic [7:0]  exp_msb;
        logic [7:0]  exp_lsb;
        bit          exp_valid;
        bit          exp_ovf;
        int unsigned exp_cnt;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{"a5_basic",   8'hA5, 1'b0, 1'b0, 8'hA5, 8'hA5, 1'b1, 1'b0, 1};
        vecs[1] = '{"c0_replace", 8'hC0, 1'b1, 1'b0, 8'hC0, 8'h03, 1'b1, 1'b0, 2};
        vecs[2] = '{"3c_replace", 8'h3C, 1'b1, 1'b0, 8'h3C, 8'h3C, 1'b1, 1'b0, 3};
        vecs[3] = '{"c3_dropped", 8'hC3, 1'b0, 1'b0, 8'h3C, 8'h3C, 1'b1, 1'b1, 4};
        vecs[4] = '{"a5_alt_ce",  8'hA5, 1'b1, 1'b1, 8'hA5, 8'hA5, 1'b1, 1'b1, 5};

        tick(1, 0, 0, 0, 0);
        tick(1, 1, 1, 1, 1);
        check_outs("reset", 8'h00, 8'h00, 0, 0, 0);

        foreach (vecs[i]) begin
            send_word(vecs[i].word, vecs[i].ready_end, vecs[i].alt, 1'b1);
            check_outs(vecs[i].name, vecs[i].exp_msb, vecs[i].exp_lsb, vecs[i].exp_valid,
                       vecs[i].exp_ovf, vecs[i].exp_cnt);
        end

        // READY pulse without completion clears VALID; OVERFLOW is sticky.
        tick(0, 0, 0, 0, 1);
        check_outs("ready_pulse", 8'hA5, 8'hA5, 0, 1, 5);
        tick(0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        check_outs("reset2", 8'h00, 8'h00, 0, 0, 0);

        // Partial word discarded by SYNC.
        tick(0, 1, 1, 0, 0);
        tick(0, 1, 1, 0, 0);
        tick(0, 1, 1, 0, 0);
        send_word(8'h5A, 0, 0, 1'b1);
        check_outs("partial_then_5a", 8'h5A, 8'h5A, 1, 0, 1);

        // SYNC on the would-be completion edge wins.
        tick(0, 0, 0, 0, 1);
        tick(0, 1, 1, 1, 0);
        for (int i = 0; i < 6; i++) tick(0, 1, 1, 0, 0);
        tick(0, 1, 0, 1, 0);
        check_outs("sync_on_last", 8'h5A, 8'h5A, 0, 0, 1);
        for (int i = 0; i < 7; i++) tick(0, 1, bit'(i % 2), 0, 0);
        check_outs("after_sync_word", 8'h2A, 8'h54, 1, 0, 2);

        // Back-to-back replace with READY on the completion edge.
        tick(0, 0, 0, 0, 1);
        send_word(8'h11, 0, 0, 1'b1);
        send_word(8'h22, 1, 0, 1'b1);
        check_outs("11_then_22", 8'h22, 8'h44, 1, 0, 4);
        for (int i = 0; i < 4; i++) tick(0, 1, 1, 0, 0);
        tick(1, 1, 1, 0, 0);
        check_outs("reset_mid_word", 8'h00, 8'h00, 0, 0, 0);
        send_word(8'h96, 0, 0, 1'b0);
        check_outs("clean_after_reset", 8'h96, 8'h69, 1, 0, 1);

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            tick(($urandom_range(199, 0) == 0), ($urandom_range(9, 0) < 7),
                 bit'($urandom & 1), ($urandom_range(19, 0) == 0),
                 ($urandom_range(9, 0) < 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
